alu_result_writeback: RTL and testbench
=======================================

Name: alu_result_writeback

Overview:
- Downstream stage of the combinational ALU. Captures the ALU result (R) and flag vector (FlagsOut) for each issued operation, queues them in a 2-entry skid buffer with valid/ready handshakes, and presents them to the register-file write port.
- Owns the architectural flags register. Its output drives the ALU FlagsIn, closing the flag loop through a register.

Parameters:
- L, 16, datapath and flag-vector width.
- P, 0, operation-code MSB; the operation field is P+1 bits.
- FLAG_COUNT, 4, number of defined low flag bits (bit0 MulOverflow, bit1 DivHasRemainder, bit2 DivByZero, bit3 DivOverflow).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- InValid  in  1  ALU output is valid this cycle.
- InReady  out  1  stage can accept an entry.
- InOperation  in  P+1  opcode that produced InR.
- InR  in  L  ALU result.
- InFlags  in  L  ALU FlagsOut.
- FlagsReg  out  L  architectural flags; drives ALU FlagsIn.
- FlagsClear  in  1  synchronous clear of FlagsReg[FLAG_COUNT-1:0].
- OutValid  out  1  head entry valid.
- OutReady  in  1  consumer accepts the head entry.
- OutOperation  out  P+1  head entry opcode.
- OutR  out  L  head entry result.
- OutFlags  out  L  head entry flag snapshot.
- RetiredCount  out  L  number of entries popped, wraps modulo 2^L.

Behaviour:
- Reset (ResetN=0, asynchronous): count=0, OutValid=0, InReady=1, FlagsReg=0, RetiredCount=0, OutR/OutFlags/OutOperation=0, both storage entries=0.
- Push: InValid&&InReady. Pop: OutValid&&OutReady.
- InReady = (count!=2), decoded from registered count only, with no combinational path from OutReady.
- OutValid = (count!=0). Out* always show the head entry; they are stable while OutValid&&!OutReady.
- Latency: an entry pushed in cycle N is visible on Out* in cycle N+1. No same-cycle bypass.
- Storage: 2-entry circular buffer with 1-bit read and write pointers that wrap 1->0. count updates +1 on push only, -1 on pop only, unchanged on push+pop.
- count=2: InReady=0, so a push is impossible. A pop that cycle makes InReady=1 in the next cycle.
- count=0: pop is impossible. Push and pop in the same cycle is not a bypass; the entry appears next cycle.
- Flags register:
  - On push, FlagsReg <= InFlags (all L bits).
  - If FlagsClear is asserted in the same cycle as a push, bits [FLAG_COUNT-1:0] clear to 0 and bits [L-1:FLAG_COUNT] take InFlags.
  - FlagsClear without a push clears only bits [FLAG_COUNT-1:0]; upper bits hold.
  - The queued entry always stores the unmodified InFlags.
- RetiredCount increments by 1 on each pop and wraps from 2^L-1 to 0.
- InValid while InReady=0 is not an error; the producer holds its data.
- Reset mid-operation discards all queued entries immediately, with no drain.

Optional Feature:
- Macro ALU_WB_DIVZERO_TRAP_EN.
- Defined:
  - Adds output Trap (1 bit, reset 0) and input TrapAck (1 bit).
  - Pushing an entry with InFlags[2]=1 sets Trap in the next cycle.
  - While Trap=1, InReady is forced to 0. The queue still drains.
  - TrapAck while Trap=1 clears Trap in the next cycle. A new trap-causing push cannot occur while Trap=1.
- Undefined: no Trap/TrapAck ports, and DivByZero is recorded only in the flags.

Test Plan:
- Reset, then idle: OutValid=0, InReady=1, FlagsReg=0x0000, RetiredCount=0. Assert ResetN=0 while count=2: outputs return to reset values with no clock edge.
- Push InR=0x0007, InFlags=0x0002, Op=0 with OutReady=1: the next cycle shows OutValid=1, OutR=0x0007, FlagsReg=0x0002. The cycle after, OutValid=0 and RetiredCount=1.
- Backpressure: OutReady=0 and push 0x0011 then 0x0022. count=2, InReady=0, and OutR holds 0x0011. Raise OutReady: pops occur in order 0x0011 then 0x0022, and InReady returns to 1 after the first pop.
- Steady push+pop at count=1 for 10 cycles with values 1..10: output order is 1..10, count stays 1, RetiredCount=10. Pointer wrap is covered.
- FlagsClear with a simultaneous push of InFlags=0x801F: FlagsReg=0x8010 and the queued OutFlags=0x801F. FlagsClear alone afterwards leaves FlagsReg=0x8010.
- With ALU_WB_DIVZERO_TRAP_EN: push InFlags=0x0004, so Trap=1 and InReady=0 while the entry still pops. TrapAck clears Trap next cycle and InReady returns to 1. RetiredCount=0xFFFF followed by one pop wraps to 0x0000.

Source files
------------

// File: rtl/alu_result_writeback_if.sv
// ---------------------------------------------------------------------------
// alu_result_writeback_if
//   Handshake and data bundle between the ALU, the writeback stage and the
//   register-file write port.
//
//   Parameters: L (datapath / flag width), P (opcode MSB).
//   Producer side : InValid, InReady, InOperation, InR, InFlags
//   Flags side    : FlagsReg (architectural flags), FlagsClear
//   Consumer side : OutValid, OutReady, OutOperation, OutR, OutFlags
//   Statistics    : RetiredCount
//   With ALU_WB_DIVZERO_TRAP_EN defined: Trap, TrapAck are added.
//
//   modport slave  : the writeback stage
//   modport master : the environment driving/consuming the stage
// ---------------------------------------------------------------------------
interface alu_result_writeback_if #(
  parameter int L = 16,
  parameter int P = 0
);
  logic         InValid;
  logic         InReady;
  logic [P:0]   InOperation;
  logic [L-1:0] InR;
  logic [L-1:0] InFlags;
  logic [L-1:0] FlagsReg;
  logic         FlagsClear;
  logic         OutValid;
  logic         OutReady;
  logic [P:0]   OutOperation;
  logic [L-1:0] OutR;
  logic [L-1:0] OutFlags;
  logic [L-1:0] RetiredCount;
`ifdef ALU_WB_DIVZERO_TRAP_EN
  logic         Trap;
  logic         TrapAck;
`endif

  modport slave (
    input  InValid, InOperation, InR, InFlags, FlagsClear, OutReady,
    output InReady, FlagsReg, OutValid, OutOperation, OutR, OutFlags,
           RetiredCount
`ifdef ALU_WB_DIVZERO_TRAP_EN
    , input TrapAck
    , output Trap
`endif
  );

  modport master (
    output InValid, InOperation, InR, InFlags, FlagsClear, OutReady,
    input  InReady, FlagsReg, OutValid, OutOperation, OutR, OutFlags,
           RetiredCount
`ifdef ALU_WB_DIVZERO_TRAP_EN
    , output TrapAck
    , input Trap
`endif
  );
endinterface

// File: rtl/alu_result_writeback.sv
// ---------------------------------------------------------------------------
// alu_result_writeback
//   Writeback stage behind the combinational ALU. Each accepted ALU result
//   (opcode, result, flag vector) is queued in a 2-entry skid buffer and
//   presented to the register-file write port one cycle later. The stage also
//   owns the architectural flags register that feeds the ALU FlagsIn.
//
//   Ports:
//     Clk     : clock, rising edge
//     ResetN  : asynchronous active-low reset, discards queued entries
//     wb      : alu_result_writeback_if.slave (see interface header)
//
//   Every output is driven straight from a flop; next-state values are built
//   in one combinational block and loaded together.
//
//   Optional feature macro: ALU_WB_DIVZERO_TRAP_EN
//     Defined  : Trap/TrapAck are present. Accepting an entry whose
//                DivByZero flag is set raises Trap, which blocks further
//                input until acknowledged; the queue keeps draining.
//     Undefined: DivByZero is only recorded in the flags.
// ---------------------------------------------------------------------------
module alu_result_writeback #(
  parameter int L          = 16,
  parameter int P          = 0,
  parameter int FLAG_COUNT = 4
) (
  input logic                  Clk,
  input logic                  ResetN,
  alu_result_writeback_if.slave wb
);

  // Entry layout: {opcode, result, flags}
  localparam int EW = P + 1 + 2 * L;
  localparam logic [L-1:0] LOW_FLAGS_MASK =
    {{(L - FLAG_COUNT){1'b0}}, {FLAG_COUNT{1'b1}}};
`ifdef ALU_WB_DIVZERO_TRAP_EN
  localparam int DIV_ZERO_BIT = 2;
`endif

  logic [EW-1:0] mem_r      [2];
  logic [EW-1:0] mem_next_s [2];
  logic          wr_ptr_r;
  logic          rd_ptr_r;
  logic          wr_ptr_next_s;
  logic          rd_ptr_next_s;
  logic [1:0]    count_r;
  logic [1:0]    count_next_s;
  logic          push_s;
  logic          pop_s;
  logic [L-1:0]  flags_r;
  logic [L-1:0]  flags_next_s;
  logic [L-1:0]  retired_r;
  logic [L-1:0]  retired_next_s;
  logic          in_ready_r;
  logic          in_ready_next_s;
  logic          out_valid_r;
  logic [EW-1:0] head_r;
  logic [EW-1:0] head_next_s;
  logic          trap_next_s;
`ifdef ALU_WB_DIVZERO_TRAP_EN
  logic          trap_r;
`endif

  // Handshake qualification; only registered ready/valid are used, so there
  // is no combinational path from OutReady to InReady.
  always_comb begin
    push_s = wb.InValid & in_ready_r;
    pop_s  = out_valid_r & wb.OutReady;
  end

  // Next-state computation for queue, flags, statistics and trap.
  always_comb begin
    mem_next_s = mem_r;
    if (push_s) begin
      mem_next_s[wr_ptr_r] = {wb.InOperation, wb.InR, wb.InFlags};
    end else begin
      mem_next_s = mem_r;
    end

    wr_ptr_next_s = push_s ? ~wr_ptr_r : wr_ptr_r;
    rd_ptr_next_s = pop_s  ? ~rd_ptr_r : rd_ptr_r;

    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase

    // The head register already looks at post-update storage so a freshly
    // pushed entry into an empty (or draining) queue appears next cycle.
    head_next_s = mem_next_s[rd_ptr_next_s];

    // The queued entry keeps raw InFlags; only the architectural copy is
    // subject to FlagsClear.
    if (push_s) begin
      flags_next_s = wb.FlagsClear ? (wb.InFlags & ~LOW_FLAGS_MASK) : wb.InFlags;
    end else if (wb.FlagsClear) begin
      flags_next_s = flags_r & ~LOW_FLAGS_MASK;
    end else begin
      flags_next_s = flags_r;
    end

    retired_next_s = pop_s ? (retired_r + {{(L-1){1'b0}}, 1'b1}) : retired_r;

`ifdef ALU_WB_DIVZERO_TRAP_EN
    if (push_s && wb.InFlags[DIV_ZERO_BIT]) begin
      trap_next_s = 1'b1;
    end else if (trap_r && wb.TrapAck) begin
      trap_next_s = 1'b0;
    end else begin
      trap_next_s = trap_r;
    end
`else
    trap_next_s = 1'b0;
`endif

    in_ready_next_s = (count_next_s != 2'd2) && !trap_next_s;
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      mem_r[0]    <= {EW{1'b0}};
      mem_r[1]    <= {EW{1'b0}};
      wr_ptr_r    <= 1'b0;
      rd_ptr_r    <= 1'b0;
      count_r     <= 2'd0;
      flags_r     <= {L{1'b0}};
      retired_r   <= {L{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      head_r      <= {EW{1'b0}};
`ifdef ALU_WB_DIVZERO_TRAP_EN
      trap_r      <= 1'b0;
`endif
    end else begin
      mem_r[0]    <= mem_next_s[0];
      mem_r[1]    <= mem_next_s[1];
      wr_ptr_r    <= wr_ptr_next_s;
      rd_ptr_r    <= rd_ptr_next_s;
      count_r     <= count_next_s;
      flags_r     <= flags_next_s;
      retired_r   <= retired_next_s;
      in_ready_r  <= in_ready_next_s;
      out_valid_r <= (count_next_s != 2'd0);
      head_r      <= head_next_s;
`ifdef ALU_WB_DIVZERO_TRAP_EN
      trap_r      <= trap_next_s;
`endif
    end
  end

  assign wb.InReady      = in_ready_r;
  assign wb.OutValid     = out_valid_r;
  assign wb.OutOperation = head_r[EW-1 -: P+1];
  assign wb.OutR         = head_r[2*L-1 -: L];
  assign wb.OutFlags     = head_r[L-1:0];
  assign wb.FlagsReg     = flags_r;
  assign wb.RetiredCount = retired_r;
`ifdef ALU_WB_DIVZERO_TRAP_EN
  assign wb.Trap         = trap_r;
`endif

endmodule

// File: tb/tb_alu_result_writeback.sv
// ---------------------------------------------------------------------------
// tb_alu_result_writeback
//   Inputs change 1 time unit after the rising edge. A monitor on the falling
//   edge compares the DUT against a queue-based reference model, then applies
//   this cycle's handshakes to the model. Directed checks at named points
//   cover the listed scenarios; a random phase and a RetiredCount wrap run
//   follow.
// ---------------------------------------------------------------------------
module tb_alu_result_writeback;
  localparam int L = 16;
  localparam int P = 0;
  localparam logic [L-1:0] LOW_MASK = L'((1 << 4) - 1);

  logic Clk = 1'b0;
  logic ResetN = 1'b0;
  always #5 Clk = ~Clk;

  alu_result_writeback_if #(.L(L), .P(P)) wb ();

  alu_result_writeback #(.L(L), .P(P), .FLAG_COUNT(4)) dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .wb     (wb)
  );

  typedef struct {
    logic [P:0]   op;
    logic [L-1:0] r;
    logic [L-1:0] f;
  } entry_t;

  entry_t       q[$];
  logic [L-1:0] flags_m = '0;
  logic [L-1:0] ret_m   = '0;
  logic         trap_m  = 1'b0;
  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference model and scoreboard monitor.
  always @(negedge Clk) begin
    logic   exp_ready;
    logic   push;
    logic   pop;
    entry_t e;
    if (!ResetN) begin
      q.delete();
      flags_m = '0;
      ret_m   = '0;
      trap_m  = 1'b0;
    end else begin
      exp_ready = (q.size() != 2) && !trap_m;
      check("OutValid", wb.OutValid, q.size() != 0);
      check("InReady", wb.InReady, exp_ready);
      check("FlagsReg", wb.FlagsReg, flags_m);
      check("RetiredCount", wb.RetiredCount, ret_m);
`ifdef ALU_WB_DIVZERO_TRAP_EN
      check("Trap", wb.Trap, trap_m);
`endif
      if (q.size() != 0) begin
        check("OutOperation", wb.OutOperation, q[0].op);
        check("OutR", wb.OutR, q[0].r);
        check("OutFlags", wb.OutFlags, q[0].f);
      end
      pop  = (q.size() != 0) && wb.OutReady;
      push = wb.InValid && exp_ready;
      if (pop) begin
        void'(q.pop_front());
        ret_m = ret_m + 1'b1;
      end
      if (push) begin
        e.op = wb.InOperation;
        e.r  = wb.InR;
        e.f  = wb.InFlags;
        q.push_back(e);
        flags_m = wb.FlagsClear ? (wb.InFlags & ~LOW_MASK) : wb.InFlags;
      end else if (wb.FlagsClear) begin
        flags_m = flags_m & ~LOW_MASK;
      end
`ifdef ALU_WB_DIVZERO_TRAP_EN
      if (push && wb.InFlags[2]) trap_m = 1'b1;
      else if (trap_m && wb.TrapAck) trap_m = 1'b0;
`endif
    end
  end

  task automatic drive(input logic v, input logic [P:0] op, input logic [L-1:0] r, input logic [L-1:0] f);
    wb.InValid     = v;
    wb.InOperation = op;
    wb.InR         = r;
    wb.InFlags     = f;
  endtask

  initial begin
    drive(1'b0, '0, '0, '0);
    wb.FlagsClear = 1'b0;
    wb.OutReady   = 1'b0;
`ifdef ALU_WB_DIVZERO_TRAP_EN
    wb.TrapAck    = 1'b0;
`endif
    repeat (3) tick();
    check("rst_OutValid", wb.OutValid, 1'b0);
    check("rst_InReady", wb.InReady, 1'b1);
    check("rst_FlagsReg", wb.FlagsReg, 16'h0000);
    check("rst_Retired", wb.RetiredCount, 16'h0000);
    ResetN = 1'b1;
    repeat (2) tick();

    // Single push with immediate consumption.
    wb.OutReady = 1'b1;
    drive(1'b1, 1'b0, 16'h0007, 16'h0002);
    tick();
    drive(1'b0, '0, '0, '0);
    check("t1_OutValid", wb.OutValid, 1'b1);
    check("t1_OutR", wb.OutR, 16'h0007);
    check("t1_FlagsReg", wb.FlagsReg, 16'h0002);
    tick();
    check("t1_OutValid_after", wb.OutValid, 1'b0);
    check("t1_Retired", wb.RetiredCount, 16'h0001);

    // Backpressure fills both entries.
    wb.OutReady = 1'b0;
    drive(1'b1, 1'b0, 16'h0011, 16'h0000);
    tick();
    drive(1'b1, 1'b0, 16'h0022, 16'h0000);
    tick();
    drive(1'b0, '0, '0, '0);
    check("bp_InReady_full", wb.InReady, 1'b0);
    check("bp_OutR_hold", wb.OutR, 16'h0011);
    tick();
    check("bp_OutR_hold2", wb.OutR, 16'h0011);
    wb.OutReady = 1'b1;
    tick();
    check("bp_OutR_second", wb.OutR, 16'h0022);
    check("bp_InReady_back", wb.InReady, 1'b1);
    tick();
    check("bp_empty", wb.OutValid, 1'b0);

    // Steady push+pop at occupancy one.
    for (int v = 1; v <= 10; v++) begin
      drive(1'b1, 1'b1, L'(v), 16'h0000);
      tick();
    end
    drive(1'b0, '0, '0, '0);
    tick();
    check("stream_Retired", wb.RetiredCount, 16'd13);

    // FlagsClear with and without a push.
    wb.OutReady   = 1'b0;
    wb.FlagsClear = 1'b1;
    drive(1'b1, 1'b0, 16'h1234, 16'h801F);
    tick();
    drive(1'b0, '0, '0, '0);
    wb.FlagsClear = 1'b0;
    check("fc_FlagsReg", wb.FlagsReg, 16'h8010);
    check("fc_OutFlags", wb.OutFlags, 16'h801F);
    wb.FlagsClear = 1'b1;
    tick();
    wb.FlagsClear = 1'b0;
    check("fc_alone", wb.FlagsReg, 16'h8010);
    wb.OutReady = 1'b1;
    tick();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [L-1:0] f;
      f = L'($urandom);
      if ($urandom_range(0, 15) != 0) f[2] = 1'b0;
      drive(1'($urandom_range(0, 1)), 1'($urandom), L'($urandom), f);
      wb.OutReady   = ($urandom_range(0, 3) != 0);
      wb.FlagsClear = ($urandom_range(0, 7) == 0);
`ifdef ALU_WB_DIVZERO_TRAP_EN
      wb.TrapAck    = ($urandom_range(0, 3) == 0);
`endif
      tick();
    end
    drive(1'b0, '0, '0, '0);
    wb.FlagsClear = 1'b0;
    wb.OutReady   = 1'b1;
`ifdef ALU_WB_DIVZERO_TRAP_EN
    wb.TrapAck    = 1'b1;
`endif
    repeat (3) tick();
`ifdef ALU_WB_DIVZERO_TRAP_EN
    wb.TrapAck = 1'b0;
    tick();

    // Divide-by-zero trap.
    wb.OutReady = 1'b0;
    drive(1'b1, 1'b0, 16'h00AA, 16'h0004);
    tick();
    drive(1'b0, '0, '0, '0);
    check("trap_set", wb.Trap, 1'b1);
    check("trap_InReady", wb.InReady, 1'b0);
    check("trap_OutValid", wb.OutValid, 1'b1);
    wb.OutReady = 1'b1;
    tick();
    check("trap_drained", wb.OutValid, 1'b0);
    check("trap_held", wb.Trap, 1'b1);
    wb.TrapAck = 1'b1;
    tick();
    wb.TrapAck = 1'b0;
    check("trap_cleared", wb.Trap, 1'b0);
    check("trap_InReady_back", wb.InReady, 1'b1);
`endif

    // Asynchronous reset while full, sampled before any clock edge.
    wb.OutReady = 1'b0;
    drive(1'b1, 1'b1, 16'h0033, 16'h0101);
    tick();
    drive(1'b1, 1'b0, 16'h0044, 16'h0202);
    tick();
    drive(1'b0, '0, '0, '0);
    check("full_InReady", wb.InReady, 1'b0);
    ResetN = 1'b0;
    #1;
    check("async_OutValid", wb.OutValid, 1'b0);
    check("async_InReady", wb.InReady, 1'b1);
    check("async_FlagsReg", wb.FlagsReg, 16'h0000);
    check("async_Retired", wb.RetiredCount, 16'h0000);
    check("async_OutR", wb.OutR, 16'h0000);
    check("async_OutFlags", wb.OutFlags, 16'h0000);
    tick();
    ResetN = 1'b1;
    tick();

    // RetiredCount wrap through continuous streaming.
    wb.OutReady = 1'b1;
    for (int i = 0; i < 70000 && ret_m != 16'hFFFF; i++) begin
      drive(1'b1, 1'b0, L'($urandom), L'($urandom) & 16'hFFFB);
      tick();
    end
    drive(1'b0, '0, '0, '0);
    check("wrap_pre", wb.RetiredCount, 16'hFFFF);
    tick();
    check("wrap_post", wb.RetiredCount, 16'h0000);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
